// File: rtl/temp_digit_feeder.sv
// Converts a DS18B20 temperature word into four display symbols (sign/hundreds,
// tens, units with decimal point, tenths) and serves them one at a time on request.
module temp_digit_feeder #(
    parameter int         NUM_SYM    = 4,
    parameter logic [3:0] BLANK_CODE = 4'hF,
    parameter logic [3:0] MINUS_CODE = 4'hA
) (
    input  logic        clk_50MHz,
    input  logic        rst,
    input  logic [15:0] temp_raw,
    input  logic        temp_valid,
    input  logic        rdsig_nextdata,
    output logic [4:0]  data,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ABS   = 2'd1;
    localparam logic [1:0] ST_CONV  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
    localparam logic [1:0] LAST_IDX = 2'(NUM_SYM - 1);
    localparam logic [4:0] BLANK_SYM = {1'b0, BLANK_CODE};

    // Double-dabble correction: any BCD nibble of 5 or more gets 3 added before the shift.
    function automatic logic [3:0] nib_adjust(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd5) begin
            res = nib + 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

    logic [1:0]  state_r;
    logic        busy_r;
    logic        neg_r;
    logic [10:0] raw_lo_r;
    logic [6:0]  bin_r;
    logic [3:0]  tenths_r;
    logic [11:0] bcd_r;
    logic [2:0]  cnt_r;
    logic [4:0]  sym_r [0:3];
    logic [1:0]  idx_r;
    logic        prev_r;
    logic [4:0]  data_r;

    logic [10:0] mag_s;
    logic [3:0]  tenths_s;
    logic [11:0] bcd_adj_s;
    logic [11:0] bcd_next_s;
    logic [4:0]  sym0_s;
    logic [4:0]  sym1_s;
    logic [4:0]  sym2_s;
    logic [4:0]  sym3_s;
    logic        rise_s;
    logic        unused_s;

    // Only bits [10:0] of the magnitude matter, and those depend only on raw[10:0].
    assign unused_s = ^temp_raw[14:11];

    // Magnitude, tenths digit and next double-dabble step.
    always_comb begin
        if (neg_r) begin
            mag_s = 11'd0 - raw_lo_r;
        end else begin
            mag_s = raw_lo_r;
        end
        // frac*10/16 == frac*5/8, truncated
        tenths_s   = 4'(({3'd0, mag_s[3:0]} * 7'd5) >> 3);
        bcd_adj_s  = {nib_adjust(bcd_r[11:8]), nib_adjust(bcd_r[7:4]), nib_adjust(bcd_r[3:0])};
        bcd_next_s = 12'({bcd_adj_s, bin_r[6]});
    end

    // Symbol composition from the finished BCD digits.
    always_comb begin
        if (neg_r) begin
            sym0_s = {1'b0, MINUS_CODE};
        end else if (bcd_r[11:8] != 4'd0) begin
            sym0_s = {1'b0, bcd_r[11:8]};
        end else begin
            sym0_s = BLANK_SYM;
        end
        if ((bcd_r[11:8] == 4'd0) && (bcd_r[7:4] == 4'd0)) begin
            sym1_s = BLANK_SYM;
        end else begin
            sym1_s = {1'b0, bcd_r[7:4]};
        end
        sym2_s = {1'b1, bcd_r[3:0]};
        sym3_s = {1'b0, tenths_r};
    end

    assign rise_s = rdsig_nextdata & ~prev_r;

    // Conversion FSM: capture, absolute value, seven shift steps, load symbols.
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
            neg_r    <= 1'b0;
            raw_lo_r <= 11'd0;
            bin_r    <= 7'd0;
            tenths_r <= 4'd0;
            bcd_r    <= 12'd0;
            cnt_r    <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                sym_r[i] <= BLANK_SYM;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (temp_valid) begin
                        neg_r    <= temp_raw[15];
                        raw_lo_r <= temp_raw[10:0];
                        busy_r   <= 1'b1;
                        state_r  <= ST_ABS;
                    end
                end
                ST_ABS: begin
                    bin_r    <= mag_s[10:4];
                    tenths_r <= tenths_s;
                    bcd_r    <= 12'd0;
                    cnt_r    <= 3'd0;
                    state_r  <= ST_CONV;
                end
                ST_CONV: begin
                    bcd_r <= bcd_next_s;
                    bin_r <= {bin_r[5:0], 1'b0};
                    if (cnt_r == 3'd6) begin
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
                ST_DONE: begin
                    sym_r[0] <= sym0_s;
                    sym_r[1] <= sym1_s;
                    sym_r[2] <= sym2_s;
                    sym_r[3] <= sym3_s;
                    busy_r   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Request edge detection, symbol index and registered output.
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            prev_r <= 1'b0;
            idx_r  <= 2'd0;
            data_r <= BLANK_SYM;
        end else begin
            prev_r <= rdsig_nextdata;
            if (rise_s) begin
                idx_r <= (idx_r == LAST_IDX) ? 2'd0 : idx_r + 2'd1;
            end
            data_r <= sym_r[idx_r];
        end
    end

    assign data = data_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_temp_digit_feeder.sv
// Scoreboard bench for temp_digit_feeder: request pulses push expected symbols,
// a monitor pops and compares when the symbol for each request edge is presented.
module tb_temp_digit_feeder;

    logic        clk_50MHz = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] temp_raw = 16'h0000;
    logic        temp_valid = 1'b0;
    logic        rdsig_nextdata = 1'b0;
    logic [4:0]  data;
    logic        busy;

    typedef struct {
        string      name;
        logic [4:0] exp;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur_e;
    logic [4:0] model_sym [0:3];
    int         model_idx = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       tb_prev = 1'b0;
    logic       rise_d1 = 1'b0;
    logic       rise_d2 = 1'b0;

    temp_digit_feeder dut (
        .clk_50MHz      (clk_50MHz),
        .rst            (rst),
        .temp_raw       (temp_raw),
        .temp_valid     (temp_valid),
        .rdsig_nextdata (rdsig_nextdata),
        .data           (data),
        .busy           (busy)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    // Track request edges as the bench drove them; data shows the result two edges later.
    always @(posedge clk_50MHz) begin
        tb_prev <= rdsig_nextdata;
        rise_d1 <= rdsig_nextdata & ~tb_prev;
        rise_d2 <= rise_d1;
    end

    // Monitor: pop and compare once per presented symbol.
    always @(negedge clk_50MHz) begin
        if (rise_d2) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_underflow: data=%h presented with no expected entry", data);
            end else begin
                cur_e = exp_q.pop_front();
                if (data !== cur_e.exp) begin
                    n_bad++;
                    $display("FAIL %s: data=%h expected=%h", cur_e.name, data, cur_e.exp);
                end
            end
        end
    end

    task automatic check_val(input string nm, input logic [4:0] act, input logic [4:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        model_idx = 0;
        for (int i = 0; i < 4; i++) model_sym[i] = 5'h0F;
    endtask

    task automatic pulse(input string nm);
        @(negedge clk_50MHz);
        rdsig_nextdata = 1'b1;
        model_idx = (model_idx + 1) % 4;
        exp_q.push_back('{nm, model_sym[model_idx]});
        @(negedge clk_50MHz);
        rdsig_nextdata = 1'b0;
        repeat (3) @(negedge clk_50MHz);
    endtask

    task automatic pulse4(input string nm);
        for (int i = 0; i < 4; i++) pulse(nm);
    endtask

    // Issue a conversion; optionally inject a second strobe at negedge inj (sampled one edge later).
    task automatic convert(input string nm, input logic [15:0] raw,
                           input logic [4:0] s0, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [4:0] s3,
                           input int inj, input logic [15:0] raw2);
        @(negedge clk_50MHz);
        temp_raw   = raw;
        temp_valid = 1'b1;
        @(negedge clk_50MHz);
        temp_valid = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            check_val({nm, "_busy_hi"}, {4'd0, busy}, 5'd1);
            if (i == inj) begin
                temp_raw   = raw2;
                temp_valid = 1'b1;
            end else begin
                temp_valid = 1'b0;
            end
            @(negedge clk_50MHz);
        end
        temp_valid = 1'b0;
        check_val({nm, "_busy_lo"}, {4'd0, busy}, 5'd0);
        @(negedge clk_50MHz);
        model_sym[0] = s0;
        model_sym[1] = s1;
        model_sym[2] = s2;
        model_sym[3] = s3;
        check_val({nm, "_first"}, data, model_sym[model_idx]);
        pulse4(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk_50MHz);
        rst = 1'b0;
        @(negedge clk_50MHz);
        check_val("reset_data", data, 5'h0F);
        check_val("reset_busy", {4'd0, busy}, 5'd0);
        pulse4("reset_syms");

        convert("t25",   16'h0191, 5'h0F, 5'h02, 5'h15, 5'h00, 0, 16'h0000);
        convert("tm10",  16'hFF5E, 5'h0A, 5'h01, 5'h10, 5'h01, 0, 16'h0000);
        convert("t125",  16'h07D0, 5'h01, 5'h02, 5'h15, 5'h00, 0, 16'h0000);
        convert("tm55",  16'hFC90, 5'h0A, 5'h05, 5'h15, 5'h00, 0, 16'h0000);
        convert("t0",    16'h0000, 5'h0F, 5'h0F, 5'h10, 5'h00, 0, 16'h0000);
        convert("drop2", 16'h0191, 5'h0F, 5'h02, 5'h15, 5'h00, 2, 16'h07D0);
        repeat (12) @(negedge clk_50MHz);
        check_val("drop2_idle", {4'd0, busy}, 5'd0);
        check_val("drop2_hold", data, 5'h0F);

        // Reset during the 4th shift cycle must abort and leave blank symbols.
        @(negedge clk_50MHz);
        temp_raw   = 16'h07D0;
        temp_valid = 1'b1;
        @(negedge clk_50MHz);
        temp_valid = 1'b0;
        repeat (4) @(negedge clk_50MHz);
        rst = 1'b1;
        @(negedge clk_50MHz);
        rst = 1'b0;
        model_reset();
        check_val("abort_busy", {4'd0, busy}, 5'd0);
        check_val("abort_data", data, 5'h0F);
        repeat (12) @(negedge clk_50MHz);
        check_val("abort_busy_late", {4'd0, busy}, 5'd0);
        check_val("abort_data_late", data, 5'h0F);
        pulse4("abort_syms");

        // Held request level advances only once.
        convert("held", 16'h0191, 5'h0F, 5'h02, 5'h15, 5'h00, 0, 16'h0000);
        @(negedge clk_50MHz);
        rdsig_nextdata = 1'b1;
        model_idx = 1;
        exp_q.push_back('{"held_rise", model_sym[1]});
        repeat (100) @(negedge clk_50MHz);
        check_val("held_once", data, 5'h02);
        rdsig_nextdata = 1'b0;
        repeat (3) @(negedge clk_50MHz);
        pulse("held_next");
        pulse("held_next");
        pulse("held_wrap");

        repeat (5) @(negedge clk_50MHz);
        check_val("sb_drained", 5'(exp_q.size()), 5'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
